peripheral_msi_data_sequencer_wb: RTL

- Sequencing controller bridging a 32-bit Wishbone master to an 8-bit Wishbone slave.
- Splits each master access into one classic 8-bit slave cycle per asserted byte select, highest lane first, then returns a single master response.
- Adds multi-byte support and a slave-response timeout; sits between CPU-side bus and byte-wide peripherals.

---
 rtl/peripheral_msi_data_sequencer_wb.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/peripheral_msi_data_sequencer_wb.sv
// Bridges 32-bit Wishbone master accesses onto an 8-bit classic Wishbone slave:
// one byte beat per selected lane (lane 3 first), per-beat no-response timeout, single master response.
module peripheral_msi_data_sequencer_wb #(
  parameter int AW        = 32,
  parameter int TO_CYCLES = 256
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [AW-1:0] wbm_adr_i,
  input  logic [31:0]   wbm_dat_i,
  input  logic [3:0]    wbm_sel_i,
  input  logic          wbm_we_i,
  input  logic          wbm_cyc_i,
  input  logic          wbm_stb_i,
  output logic [31:0]   wbm_dat_o,
  output logic          wbm_ack_o,
  output logic          wbm_err_o,
  output logic          wbm_rty_o,
  output logic [AW-1:0] wbs_adr_o,
  output logic [7:0]    wbs_dat_o,
  output logic          wbs_we_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic [2:0]    wbs_cti_o,
  output logic [1:0]    wbs_bte_o,
  input  logic [7:0]    wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_err_i,
  input  logic          wbs_rty_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_RESP} state_e;
  typedef enum logic [1:0] {R_ACK, R_ERR, R_RTY} resp_e;

  localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

  state_e          state_q;
  resp_e           resp_q;
  logic [AW-3:0]   adr_q;
  logic [31:0]     wdat_q;
  logic [31:0]     acc_q;
  logic [3:0]      mask_q;
  logic            we_q;
  logic [CW-1:0]   cnt_q;

  logic [31:0]     wbm_dat_q;
  logic            wbm_ack_q;
  logic            wbm_err_q;
  logic            wbm_rty_q;
  logic [AW-1:0]   wbs_adr_q;
  logic [7:0]      wbs_dat_q;
  logic            wbs_we_q;
  logic            wbs_cyc_q;
  logic            wbs_stb_q;
  logic            busy_q;

  logic [1:0]      cur_lane;
  logic [1:0]      nxt_lane;
  logic [3:0]      mask_d;
  logic [31:0]     acc_d;
  logic            to_hit;
  logic            resp_pend;
  logic            unused_adr_bits;

  function automatic logic [1:0] hi_lane(input logic [3:0] m);
    if (m[3])      return 2'd3;
    else if (m[2]) return 2'd2;
    else if (m[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] l);
    case (l)
      2'd3:    return d[31:24];
      2'd2:    return d[23:16];
      2'd1:    return d[15:8];
      default: return d[7:0];
    endcase
  endfunction

  always_comb begin
    cur_lane = hi_lane(mask_q);
    mask_d   = mask_q & ~(4'b0001 << cur_lane);
    nxt_lane = hi_lane(mask_d);
    acc_d    = acc_q;
    case (cur_lane)
      2'd3:    acc_d[31:24] = wbs_dat_i;
      2'd2:    acc_d[23:16] = wbs_dat_i;
      2'd1:    acc_d[15:8]  = wbs_dat_i;
      default: acc_d[7:0]   = wbs_dat_i;
    endcase
  end

  // cnt_q counts silent cycles already spent on this beat; the abort lands on the
  // edge where the count would reach TO_CYCLES-1.
  assign to_hit = (TO_CYCLES != 0) && ((32'(cnt_q) + 32'd2) >= 32'(TO_CYCLES));

  // The master still holds stb during the response pulse, so that cycle must not re-accept.
  assign resp_pend = wbm_ack_q | wbm_err_q | wbm_rty_q;

  assign unused_adr_bits = ^wbm_adr_i[1:0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      resp_q    <= R_ACK;
      adr_q     <= '0;
      wdat_q    <= '0;
      acc_q     <= '0;
      mask_q    <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      wbm_dat_q <= '0;
      wbm_ack_q <= 1'b0;
      wbm_err_q <= 1'b0;
      wbm_rty_q <= 1'b0;
      wbs_adr_q <= '0;
      wbs_dat_q <= '0;
      wbs_we_q  <= 1'b0;
      wbs_cyc_q <= 1'b0;
      wbs_stb_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wbm_ack_q <= 1'b0;
      wbm_err_q <= 1'b0;
      wbm_rty_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wbm_cyc_i && wbm_stb_i && !resp_pend) begin
            adr_q  <= wbm_adr_i[AW-1:2];
            wdat_q <= wbm_dat_i;
            we_q   <= wbm_we_i;
            mask_q <= wbm_sel_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (wbm_sel_i == 4'h0) begin
              state_q <= S_RESP;
              resp_q  <= R_ACK;
            end else begin
              state_q   <= S_BEAT;
              wbs_cyc_q <= 1'b1;
              wbs_stb_q <= 1'b1;
              wbs_we_q  <= wbm_we_i;
              wbs_adr_q <= {wbm_adr_i[AW-1:2], ~hi_lane(wbm_sel_i)};
              wbs_dat_q <= lane_byte(wbm_dat_i, hi_lane(wbm_sel_i));
            end
          end
        end
        S_BEAT: begin
          if (!wbm_cyc_i) begin
            wbs_cyc_q <= 1'b0;
            wbs_stb_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else if (wbs_err_i || wbs_rty_i || (wbs_ack_i && mask_d == 4'h0) ||
                       (!wbs_ack_i && to_hit)) begin
            wbs_cyc_q <= 1'b0;
            wbs_stb_q <= 1'b0;
            state_q   <= S_RESP;
            if (wbs_err_i) begin
              resp_q <= R_ERR;
            end else if (wbs_rty_i) begin
              resp_q <= R_RTY;
            end else if (wbs_ack_i) begin
              resp_q <= R_ACK;
              mask_q <= mask_d;
              if (!we_q) acc_q <= acc_d;
            end else begin
              resp_q <= R_ERR;
            end
          end else if (wbs_ack_i) begin
            mask_q    <= mask_d;
            cnt_q     <= '0;
            wbs_adr_q <= {adr_q, ~nxt_lane};
            wbs_dat_q <= lane_byte(wdat_q, nxt_lane);
            if (!we_q) acc_q <= acc_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          wbm_dat_q <= acc_q;
          case (resp_q)
            R_ERR:   wbm_err_q <= 1'b1;
            R_RTY:   wbm_rty_q <= 1'b1;
            default: wbm_ack_q <= 1'b1;
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wbm_dat_o = wbm_dat_q;
  assign wbm_ack_o = wbm_ack_q;
  assign wbm_err_o = wbm_err_q;
  assign wbm_rty_o = wbm_rty_q;
  assign wbs_adr_o = wbs_adr_q;
  assign wbs_dat_o = wbs_dat_q;
  assign wbs_we_o  = wbs_we_q;
  assign wbs_cyc_o = wbs_cyc_q;
  assign wbs_stb_o = wbs_stb_q;
  assign wbs_cti_o = 3'b000;
  assign wbs_bte_o = 2'b00;
  assign busy_o    = busy_q;

endmodule
